imem_loader: RTL

//  Write-side counterpart of the instruction memory read port: accepts a program as a byte stream,

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_word_packer.sv | 45 ++++
 rtl/imem_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_WORDS      = 64;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - big-endian byte-to-word packer with a combinational word strobe
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [1:0]        byte_idx_q, byte_idx_d;

    // The completed word includes the byte being accepted now, so the top can register it this edge.
    assign word       = {shift_q[DATA_W-9:0], byte_data};
    assign word_valid = byte_valid && !clr && (byte_idx_q == 2'(BYTES_PER_WORD - 1));

    always_comb begin
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        if (clr) begin
            shift_d    = '0;
            byte_idx_d = '0;
        end else if (byte_valid) begin
            shift_d    = word;
            byte_idx_d = byte_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q    <= '0;
            byte_idx_q <= '0;
        end else begin
            shift_q    <= shift_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a LEN/DATA/CHK byte frame into instruction memory, holding the core
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [DATA_W-1:0] wd,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [7:0]        checksum_q, checksum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic              accept;
    logic              pk_clr;
    logic              pk_valid;
    logic [DATA_W-1:0] pk_word;
    logic              last_word;

    assign in_ready  = (state_q == LEN) || (state_q == DATA) || (state_q == CHECK);
    assign accept    = in_valid && in_ready;
    assign busy      = in_ready;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);
    assign cpu_hold  = busy || error;
    assign we        = we_q;
    assign wa        = wa_q;
    assign wd        = wd_q;
    assign last_word = (word_addr_q == ADDR_W'(n_q - 1'b1));

    imem_word_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (pk_clr),
        .byte_valid (accept && (state_q == DATA)),
        .byte_data  (in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_addr_d = word_addr_q;
        checksum_d  = checksum_q;
        we_d        = 1'b0;
        wa_d        = wa_q;
        wd_d        = wd_q;
        pk_clr      = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d     = LEN;
                    checksum_d  = '0;
                    word_addr_d = '0;
                    pk_clr      = 1'b1;
                end
            end
            LEN: begin
                if (accept) begin
                    if (in_data == 8'd0) begin
                        n_d     = (ADDR_W+1)'(MAX_WORDS);
                        state_d = DATA;
                    end else if (in_data <= 8'(MAX_WORDS)) begin
                        n_d     = (ADDR_W+1)'(in_data);
                        state_d = DATA;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    checksum_d = checksum_q ^ in_data;
                    if (pk_valid) begin
                        we_d        = 1'b1;
                        wa_d        = word_addr_q;
                        wd_d        = pk_word;
                        word_addr_d = word_addr_q + 1'b1;
                        // Leave DATA on the same edge so a byte arriving during the write is the CHK byte.
                        if (last_word) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    state_d = (in_data == checksum_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            n_q         <= '0;
            word_addr_q <= '0;
            checksum_q  <= '0;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_addr_q <= word_addr_d;
            checksum_q  <= checksum_d;
            we_q        <= we_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
        end
    end

endmodule
